hazard_pause_ctrl: RTL and testbench
====================================

// Module: hazard_pause_ctrl
// PURPOSE
//  Pipeline hazard controller; generates the hold/bubble/flush controls consumed by the PC, IF/ID and ID/EXE registers.
//  Detects load-use, taken jumps, instruction-bank structural conflicts and external busy.
//  Sits beside decode and drives ie_PAUSE / jump_control_ie_PAUSE into ID/EXE, plus the PC and IF/ID controls.
// PARAMETERS
//  STRUCT_CYCLES  2     IF stall cycles per MEM access to the instruction bank (legal 1..15)
//  REG_ID_W       4     width of register ids: 0-7 R0-R7, 8 T, 9 SP, 10 IH, 11 RA
//  NONE_ID        4'hF  id value meaning "no register"
//  STAT_W         16    width of the statistics counters (PAUSE_STAT_EN only)
// PORTS
//  clk_50MHz              in   1         system clock, all state updates on rising edge
//  rst                    in   1         synchronous reset, active-low
//  ie_RAM_en              in   1         EXE-stage instruction accesses RAM
//  ie_RAM_op              in   1         EXE-stage RAM op; `RAM_OP_RD = load
//  ie_WB_DEST             in   REG_ID_W  EXE-stage destination id, NONE_ID if no write
//  id_SRC_A / id_SRC_B    in   REG_ID_W  ID-stage source ids, NONE_ID if unused
//  ex_JUMP_TAKEN          in   1         jump/branch resolved taken in EXE this cycle
//  mem_IMEM_ACC           in   1         MEM stage accesses instruction bank this cycle
//  ext_BUSY               in   1         external wait (serial/flash); freezes front end
//  stat_CLR               in   1         clear statistics (PAUSE_STAT_EN only)
//  pc_PAUSE               out  1         hold PC
//  if_PAUSE               out  1         hold IF/ID
//  if_FLUSH               out  1         load NOP into IF/ID
//  ie_PAUSE               out  1         hold ID/EXE (`PAUSE_ENABLE = 1)
//  jump_control_ie_PAUSE  out  1         load NOP controls into ID/EXE
//  stall_CNT / flush_CNT  out  STAT_W    statistics (PAUSE_STAT_EN only)
// BEHAVIOUR
//  - Terms (combinational): lu = ie_RAM_en & ie_RAM_op==`RAM_OP_RD & ie_WB_DEST!=NONE_ID &
//    (ie_WB_DEST==id_SRC_A | ie_WB_DEST==id_SRC_B); NONE_ID never matches. st = mem_IMEM_ACC | state==S_STRUCT.
//  - Outputs combinational from terms + state, zero latency; strict priority busy > jump > lu > st:
//    ext_BUSY:      pc_PAUSE=1 if_PAUSE=1 ie_PAUSE=1, rest 0.
//    ex_JUMP_TAKEN: if_FLUSH=1 jump_control_ie_PAUSE=1, pc_PAUSE=0 (PC loads target), rest 0.
//    lu (st or not): pc_PAUSE=1 if_PAUSE=1 jump_control_ie_PAUSE=1, if_FLUSH=0 (hold beats flush).
//    st only:       pc_PAUSE=1 if_FLUSH=1, rest 0.
//    none:          all 0.
//  - if_PAUSE and if_FLUSH never both 1; ie_PAUSE and jump_control_ie_PAUSE never both 1.
//  - While rst==0 all outputs forced 0.
//  - FSM states S_RUN, S_STRUCT; 4-bit counter cnt.
//    S_RUN: mem_IMEM_ACC & !ext_BUSY & STRUCT_CYCLES>1 -> S_STRUCT, cnt=STRUCT_CYCLES-1; else stay.
//    S_STRUCT: ext_BUSY -> hold cnt/state; mem_IMEM_ACC -> reload cnt=STRUCT_CYCLES-1;
//      else cnt==1 -> S_RUN, cnt=0; else cnt-=1.
//    Access cycle counts as first stall cycle: one isolated access = exactly STRUCT_CYCLES st cycles.
//  - Jump during S_STRUCT: jump outputs this cycle, counter still advances; remaining st cycles follow.
//  - Synchronous reset (rst==0 at edge): state=S_RUN, cnt=0, counters 0; reset mid-stall aborts stall.
// CONFIGURATION
//  PAUSE_STAT_EN defined: stall_CNT +1 per cycle pc_PAUSE==1, flush_CNT +1 per cycle if_FLUSH==1;
//    both saturate at all-ones; stat_CLR (sync) zeroes both, wins over increment; reset zeroes both.
//  PAUSE_STAT_EN undefined: stat_CLR, stall_CNT, flush_CNT ports absent; no counter logic.
// TESTING
//  1 load R3 in EXE (ie_WB_DEST=3, RAM rd), id_SRC_A=3 -> 1 cycle pc_PAUSE=if_PAUSE=jump_control_ie_PAUSE=1, then 0.
//  2 same with ie_WB_DEST=NONE_ID, id_SRC_B=NONE_ID, or ie_RAM_op write -> all outputs 0.
//  3 ex_JUMP_TAKEN=1 with lu=1 -> if_FLUSH=1, jump_control_ie_PAUSE=1, pc_PAUSE=0, if_PAUSE=0.
//  4 STRUCT_CYCLES=3, mem_IMEM_ACC 1-cycle pulse -> pc_PAUSE=if_FLUSH=1 exactly 3 cycles; ext_BUSY 2 cycles mid-stall -> 5.
//  5 ext_BUSY=1 with jump+lu -> only pc/if/ie_PAUSE=1; ext_BUSY drop -> jump response next cycle.
//  6 PAUSE_STAT_EN, STAT_W=4: 20 stall cycles -> stall_CNT=15; stat_CLR -> 0; rst=0 mid-stall -> S_RUN, outputs 0.

Source files
------------

// File: rtl/hazard_pause_ctrl.sv
// hazard_pause_ctrl: detects load-use, taken-jump, instruction-bank structural and external-busy hazards
// and drives the PC, IF/ID and ID/EXE hold/flush controls. Define PAUSE_STAT_EN to build the stall/flush counters.
`ifndef RAM_OP_RD
`define RAM_OP_RD 1'b1
`endif

module hazard_pause_ctrl #(
    parameter int unsigned         STRUCT_CYCLES = 2,
    parameter int unsigned         REG_ID_W      = 4,
    parameter logic [REG_ID_W-1:0] NONE_ID       = 4'hF
`ifdef PAUSE_STAT_EN
    ,
    parameter int unsigned         STAT_W        = 16
`endif
) (
    input  logic                clk_50MHz,
    input  logic                rst,
    input  logic                ie_RAM_en,
    input  logic                ie_RAM_op,
    input  logic [REG_ID_W-1:0] ie_WB_DEST,
    input  logic [REG_ID_W-1:0] id_SRC_A,
    input  logic [REG_ID_W-1:0] id_SRC_B,
    input  logic                ex_JUMP_TAKEN,
    input  logic                mem_IMEM_ACC,
    input  logic                ext_BUSY,
`ifdef PAUSE_STAT_EN
    input  logic                stat_CLR,
    output logic [STAT_W-1:0]   stall_CNT,
    output logic [STAT_W-1:0]   flush_CNT,
`endif
    output logic                pc_PAUSE,
    output logic                if_PAUSE,
    output logic                if_FLUSH,
    output logic                ie_PAUSE,
    output logic                jump_control_ie_PAUSE
);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_STRUCT = 1'b1
    } state_t;

    // The access cycle itself is the first stall cycle, so the counter only covers the remainder.
    localparam logic [3:0] RELOAD_CNT  = 4'(STRUCT_CYCLES - 1);
    localparam bit         MULTI_CYCLE = (STRUCT_CYCLES > 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_lu;
    logic       w_st;

    assign w_lu = ie_RAM_en && (ie_RAM_op == `RAM_OP_RD) && (ie_WB_DEST != NONE_ID) &&
                  ((ie_WB_DEST == id_SRC_A) || (ie_WB_DEST == id_SRC_B));
    assign w_st = mem_IMEM_ACC || (r_state == S_STRUCT);

    // Structural-stall sequencer: next state and remaining-cycle count
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (mem_IMEM_ACC && !ext_BUSY && MULTI_CYCLE) begin
                    w_state_nxt = S_STRUCT;
                    w_cnt_nxt   = RELOAD_CNT;
                end else begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = r_cnt;
                end
            end
            S_STRUCT: begin
                if (ext_BUSY) begin
                    w_state_nxt = S_STRUCT;
                    w_cnt_nxt   = r_cnt;
                end else if (mem_IMEM_ACC) begin
                    w_state_nxt = S_STRUCT;
                    w_cnt_nxt   = RELOAD_CNT;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_state_nxt = S_STRUCT;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Sequencer state register; reset aborts any stall in progress
    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pipeline controls, priority busy > jump > load-use > structural; hold beats flush
    always_comb begin
        pc_PAUSE              = 1'b0;
        if_PAUSE              = 1'b0;
        if_FLUSH              = 1'b0;
        ie_PAUSE              = 1'b0;
        jump_control_ie_PAUSE = 1'b0;
        if (!rst) begin
            pc_PAUSE = 1'b0;
        end else if (ext_BUSY) begin
            pc_PAUSE = 1'b1;
            if_PAUSE = 1'b1;
            ie_PAUSE = 1'b1;
        end else if (ex_JUMP_TAKEN) begin
            if_FLUSH              = 1'b1;
            jump_control_ie_PAUSE = 1'b1;
        end else if (w_lu) begin
            pc_PAUSE              = 1'b1;
            if_PAUSE              = 1'b1;
            jump_control_ie_PAUSE = 1'b1;
        end else if (w_st) begin
            pc_PAUSE = 1'b1;
            if_FLUSH = 1'b1;
        end else begin
            pc_PAUSE = 1'b0;
        end
    end

`ifdef PAUSE_STAT_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_flush_cnt;

    // Saturating stall/flush statistics; clear wins over increment
    always_ff @(posedge clk_50MHz) begin
        if (!rst || stat_CLR) begin
            r_stall_cnt <= {STAT_W{1'b0}};
            r_flush_cnt <= {STAT_W{1'b0}};
        end else begin
            if (pc_PAUSE && (r_stall_cnt != STAT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + STAT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (if_FLUSH && (r_flush_cnt != STAT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + STAT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_CNT = r_stall_cnt;
    assign flush_CNT = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_pause_ctrl.sv
// Scoreboard bench for hazard_pause_ctrl with STRUCT_CYCLES=3; statistics checks build with PAUSE_STAT_EN.
`ifndef RAM_OP_RD
`define RAM_OP_RD 1'b1
`endif

module tb_hazard_pause_ctrl;

    localparam int         SC   = 3;
    localparam logic [3:0] NONE = 4'hF;

    typedef struct packed {
        logic       r;
        logic       en;
        logic       rd;
        logic [3:0] d;
        logic [3:0] a;
        logic [3:0] b;
        logic       j;
        logic       im;
        logic       bz;
    } stim_t;

    logic       clk_50MHz = 1'b0;
    logic       rst = 1'b0;
    logic       ie_RAM_en = 1'b0;
    logic       ie_RAM_op = 1'b0;
    logic [3:0] ie_WB_DEST = NONE;
    logic [3:0] id_SRC_A = NONE;
    logic [3:0] id_SRC_B = NONE;
    logic       ex_JUMP_TAKEN = 1'b0;
    logic       mem_IMEM_ACC = 1'b0;
    logic       ext_BUSY = 1'b0;
    logic       pc_PAUSE, if_PAUSE, if_FLUSH, ie_PAUSE, jump_control_ie_PAUSE;
`ifdef PAUSE_STAT_EN
    logic       stat_CLR = 1'b0;
    logic [3:0] stall_CNT, flush_CNT;
    int         m_stall = 0;
    int         m_flush = 0;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    int         m_left = 0;
    logic [4:0] sb[$];
    logic [4:0] exp_v;
    logic [4:0] w_obs;

    assign w_obs = {pc_PAUSE, if_PAUSE, if_FLUSH, ie_PAUSE, jump_control_ie_PAUSE};

    hazard_pause_ctrl #(
        .STRUCT_CYCLES(SC),
        .REG_ID_W(4),
        .NONE_ID(NONE)
`ifdef PAUSE_STAT_EN
        ,
        .STAT_W(4)
`endif
    ) dut (
        .clk_50MHz(clk_50MHz),
        .rst(rst),
        .ie_RAM_en(ie_RAM_en),
        .ie_RAM_op(ie_RAM_op),
        .ie_WB_DEST(ie_WB_DEST),
        .id_SRC_A(id_SRC_A),
        .id_SRC_B(id_SRC_B),
        .ex_JUMP_TAKEN(ex_JUMP_TAKEN),
        .mem_IMEM_ACC(mem_IMEM_ACC),
        .ext_BUSY(ext_BUSY),
`ifdef PAUSE_STAT_EN
        .stat_CLR(stat_CLR),
        .stall_CNT(stall_CNT),
        .flush_CNT(flush_CNT),
`endif
        .pc_PAUSE(pc_PAUSE),
        .if_PAUSE(if_PAUSE),
        .if_FLUSH(if_FLUSH),
        .ie_PAUSE(ie_PAUSE),
        .jump_control_ie_PAUSE(jump_control_ie_PAUSE)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Expected {pc, if_pause, if_flush, ie_pause, jump_ctl} for the inputs currently applied.
    function automatic logic [4:0] model_out();
        logic lu;
        logic st;
        lu = ie_RAM_en && (ie_RAM_op == `RAM_OP_RD) && (ie_WB_DEST != NONE) &&
             ((ie_WB_DEST == id_SRC_A) || (ie_WB_DEST == id_SRC_B));
        st = mem_IMEM_ACC || (m_left > 0);
        if (!rst)               return 5'b00000;
        else if (ext_BUSY)      return 5'b11010;
        else if (ex_JUMP_TAKEN) return 5'b00101;
        else if (lu)            return 5'b11001;
        else if (st)            return 5'b10100;
        else                    return 5'b00000;
    endfunction

    // Advance the model across one rising edge, using the inputs still applied.
    task automatic tick();
        logic [4:0] o;
        @(posedge clk_50MHz);
        o = model_out();
        if (!rst) m_left = 0;
        else if (ext_BUSY) m_left = m_left;
        else if (mem_IMEM_ACC) m_left = SC - 1;
        else if (m_left > 0) m_left = m_left - 1;
`ifdef PAUSE_STAT_EN
        if (!rst || stat_CLR) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (o[4] && m_stall < 15) m_stall = m_stall + 1;
            if (o[2] && m_flush < 15) m_flush = m_flush + 1;
        end
`endif
        #1;
    endtask

    function automatic stim_t mk(input logic r, en, rd, input logic [3:0] d, a, b,
                                 input logic j, im, bz);
        stim_t s;
        s = '{r: r, en: en, rd: rd, d: d, a: a, b: b, j: j, im: im, bz: bz};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst           = s.r;
        ie_RAM_en     = s.en;
        ie_RAM_op     = s.rd ? `RAM_OP_RD : ~`RAM_OP_RD;
        ie_WB_DEST    = s.d;
        id_SRC_A      = s.a;
        id_SRC_B      = s.b;
        ex_JUMP_TAKEN = s.j;
        mem_IMEM_ACC  = s.im;
        ext_BUSY      = s.bz;
        sb.push_back(model_out());
    endtask

    stim_t IDLE, LU3, IM, BZ, JMP;

    task automatic test_reset();
        stim_t s[$];
        s.push_back(mk(1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1));
        s.push_back(mk(1'b0, 1'b1, 1'b1, 4'd3, 4'd3, NONE, 1'b0, 1'b1, 1'b0));
        s.push_back(IDLE);
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL reset[%0d] got %b want %b", i, w_obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        s.push_back(LU3);
        s.push_back(IDLE);
        s.push_back(mk(1'b1, 1'b1, 1'b1, 4'd5, NONE, 4'd5, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 1'b1, 1'b1, 4'd0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0));
        s.push_back(IDLE);
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL load_use[%0d] got %b want %b", i, w_obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_no_hazard();
        stim_t s[$];
        s.push_back(mk(1'b1, 1'b1, 1'b1, NONE, NONE, NONE, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 1'b1, 1'b1, 4'd3, 4'd5, NONE, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 1'b1, 1'b1, 4'd3, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL no_hazard[%0d] got %b want %b", i, w_obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_jump();
        stim_t s[$];
        s.push_back(mk(1'b1, 1'b1, 1'b1, 4'd3, 4'd3, NONE, 1'b1, 1'b0, 1'b0));
        s.push_back(JMP);
        s.push_back(IDLE);
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL jump[%0d] got %b want %b", i, w_obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_struct();
        stim_t s[$];
        int n_pc;
        int n_fl;
        s = '{IM, IDLE, IDLE, IDLE, IM, IDLE, BZ, BZ, IDLE, IDLE, IDLE};
        n_pc = 0;
        n_fl = 0;
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL struct[%0d] got %b want %b", i, w_obs, exp_v);
            end
            if (i >= 4) begin
                n_pc += int'(pc_PAUSE);
                n_fl += int'(if_FLUSH);
            end
            tick();
        end
        n_cmp++;
        if (n_pc != 5 || n_fl != 3) begin
            n_err++;
            $display("FAIL struct_busy_len got pc=%0d flush=%0d want pc=5 flush=3", n_pc, n_fl);
        end
    endtask

    task automatic test_busy();
        stim_t s[$];
        s.push_back(mk(1'b1, 1'b1, 1'b1, 4'd3, 4'd3, NONE, 1'b1, 1'b1, 1'b1));
        s.push_back(mk(1'b1, 1'b1, 1'b1, 4'd3, 4'd3, NONE, 1'b1, 1'b1, 1'b0));
        s.push_back(IDLE);
        s.push_back(IDLE);
        s.push_back(IDLE);
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL busy[%0d] got %b want %b", i, w_obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        s = '{IM, IM, IDLE, IDLE, IDLE, IM, JMP, IDLE, IDLE, IM, LU3, IDLE, IDLE};
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL back_to_back[%0d] got %b want %b", i, w_obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t s[$];
        s.push_back(IM);
        s.push_back(mk(1'b0, 1'b0, 1'b0, NONE, NONE, NONE, 1'b0, 1'b0, 1'b0));
        s.push_back(IDLE);
        s.push_back(IDLE);
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_mid_stall[%0d] got %b want %b", i, w_obs, exp_v);
            end
            tick();
        end
    endtask

`ifdef PAUSE_STAT_EN
    task automatic test_stats();
        stat_CLR = 1'b1;
        apply(IDLE);
        void'(sb.pop_front());
        tick();
        stat_CLR = 1'b0;
        for (int i = 0; i < 20; i++) begin
            apply(IM);
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL stats_stall[%0d] got %b want %b", i, w_obs, exp_v);
            end
            tick();
        end
        @(negedge clk_50MHz);
        n_cmp++;
        if (stall_CNT !== 4'(m_stall) || flush_CNT !== 4'(m_flush) || m_stall != 15) begin
            n_err++;
            $display("FAIL stats_sat got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     stall_CNT, flush_CNT, m_stall, m_flush);
        end
        stat_CLR = 1'b1;
        apply(IM);
        void'(sb.pop_front());
        tick();
        stat_CLR = 1'b0;
        apply(IDLE);
        @(negedge clk_50MHz);
        void'(sb.pop_front());
        n_cmp++;
        if (stall_CNT !== 4'd0 || flush_CNT !== 4'd0) begin
            n_err++;
            $display("FAIL stats_clr got stall=%0d flush=%0d want 0 0", stall_CNT, flush_CNT);
        end
        tick();
        apply(IDLE);
        void'(sb.pop_front());
        tick();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        IDLE = mk(1'b1, 1'b0, 1'b0, NONE, NONE, NONE, 1'b0, 1'b0, 1'b0);
        LU3  = mk(1'b1, 1'b1, 1'b1, 4'd3, 4'd3, NONE, 1'b0, 1'b0, 1'b0);
        IM   = mk(1'b1, 1'b0, 1'b0, NONE, NONE, NONE, 1'b0, 1'b1, 1'b0);
        BZ   = mk(1'b1, 1'b0, 1'b0, NONE, NONE, NONE, 1'b0, 1'b0, 1'b1);
        JMP  = mk(1'b1, 1'b0, 1'b0, NONE, NONE, NONE, 1'b1, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_no_hazard();
        test_jump();
        test_struct();
        test_busy();
        test_back_to_back();
`ifdef PAUSE_STAT_EN
        test_stats();
`endif
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
